// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// A conversion takes eight shift iterations. The digits are loaded on the last
// iteration and then held until the next completion or a reset.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     conversion request, sampled only while idle
//   bin       8-bit unsigned operand, sampled together with start
//   busy      high while the shift iterations are running
//   done      one-cycle pulse; hundreds/tens/ones are valid
//   hundreds  BCD hundreds digit (0..2)
//   tens      BCD tens digit (0..9)
//   ones      BCD ones digit (0..9)
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   sr;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       next_scratch;
  logic [BIN_W-1:0]       next_sr;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {scratch, sr} left.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted      = {adj, sr} << 1;
    next_scratch = shifted[BCD_W+BIN_W-1:BIN_W];
    next_sr      = shifted[BIN_W-1:0];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sr       <= '0;
      scratch  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sr      <= bin;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr      <= next_sr;
          scratch <= next_scratch;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(7)) begin
            hundreds <= next_scratch[11:8];
            tens     <= next_scratch[7:4];
            ones     <= next_scratch[3:0];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Any start seen here is dropped; only IDLE accepts requests.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq. The driver pushes the decimal
// digits of each accepted operand; the monitor pops and checks on every done pulse.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bin = 8'd0;
  logic       busy, done;
  logic [3:0] hundreds, tens, ones;

  bin2bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    int          stamp;
  } exp_t;

  exp_t        sb[$];
  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic        rst_seen = 1'b1;
  logic [11:0] last_exp = 12'd0;
  int          busy_cnt = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input int act, input int req);
    ncmp++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  function automatic logic [11:0] decimal(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: compares results, latency, busy length and digit hold.
  always @(negedge clk) begin
    if (rst_seen) begin
      last_exp = 12'd0;
      busy_cnt = 0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL spurious_done: got done=1 expected no done, digits %0d%0d%0d at cycle %0d",
                 hundreds, tens, ones, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("digits", int'({hundreds, tens, ones}), int'(e.d));
        chk("latency", cyc - e.stamp, 8);
        chk("busy_cycles", busy_cnt, 8);
        chk("bcd_legal", int'(hundreds <= 4'd2 && tens <= 4'd9 && ones <= 4'd9), 1);
        last_exp = e.d;
      end
      busy_cnt = 0;
    end else begin
      chk("hold", int'({hundreds, tens, ones}), int'(last_exp));
      if (busy) busy_cnt++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || done) && n < 40);
    if (busy || done) begin
      $display("FAIL idle_timeout: got busy=%0d done=%0d expected idle at cycle %0d", busy, done, cyc);
      $fatal(1, "stuck");
    end
  endtask

  // Issue one start pulse while idle; bin is scrambled afterwards.
  task automatic convert(input int v, input bit push);
    exp_t e;
    wait_idle();
    start = 1'b1;
    bin   = 8'(v);
    if (push) begin
      e.d     = decimal(v);
      e.stamp = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    bin   = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int k;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    convert(0, 1);
    convert(225, 1);
    convert(255, 1);
    convert(99, 1);
    convert(100, 1);
    drain();

    for (int v = 0; v < 256; v++) convert(v, 1);
    drain();

    for (int i = 0; i < 30; i++) convert(int'($urandom_range(255)), 1);
    drain();

    // Start held during conversion: one result, then one more after DONE.
    convert(73, 1);
    start = 1'b1;
    bin   = 8'd200;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_start_done_seen", int'(done), 1);
    @(negedge clk);
    begin
      exp_t e;
      e.d     = decimal(200);
      e.stamp = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // Abort by reset at edge k+4.
    wait_idle();
    start = 1'b1;
    bin   = 8'd255;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_digits", int'({hundreds, tens, ones}), 0);
    convert(42, 1);
    drain();

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
